// File: rtl/pair_serializer.sv
// Buffers up to DEPTH {s1,s2} sample pairs and streams them out as bytes, s1 then s2.
// Pairs offered while the buffer is full are discarded and counted in a saturating counter.
module pair_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           s1,
  input  logic [WIDTH-1:0]           s2,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // valid never depends on ready, and in_ready depends only on registered occupancy.

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               sel;
  logic [CW-1:0]      count_q;
  logic [7:0]         drop_q;
  logic [2*WIDTH-1:0] head;
  logic               push;
  logic               drop;
  logic               out_fire;
  logic               pop;

  assign in_ready   = (count_q != FULL);
  assign out_valid  = (count_q != '0);
  assign push       = in_valid && in_ready;
  assign drop       = in_valid && !in_ready;
  assign out_fire   = out_valid && out_ready;
  assign pop        = out_fire && sel;
  assign head       = mem[rd_ptr];
  assign count      = count_q;
  assign drop_count = drop_q;
  assign out_last   = out_valid && sel;

  always_comb begin
    out_data = '0;
    if (out_valid) out_data = sel ? head[WIDTH-1:0] : head[2*WIDTH-1:WIDTH];
  end

  // Storage array carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {s1, s2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      sel     <= 1'b0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (out_fire) sel <= !sel;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pair_serializer.sv
// Randomized and directed bench for pair_serializer, checked every cycle against a byte-queue model.
module tb_pair_serializer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] s1 = '0;
  logic [WIDTH-1:0] s2 = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [$clog2(DEPTH):0] count;
  logic [7:0]       drop_count;

  int n_pass  = 0;
  int n_total = 0;

  pair_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .s1(s1), .s2(s2),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .count(count),
    .drop_count(drop_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- scoreboard / model ----------------
  // The buffer is modelled as the plain sequence of bytes still owed to the consumer.
  logic [WIDTH-1:0] exp_q[$];
  int exp_drops = 0;
  bit model_ok  = 1'b0;

  always @(negedge clk) begin
    int  nbytes;
    int  pairs;
    bit  ready;
    nbytes = exp_q.size();
    pairs  = (nbytes + 1) / 2;
    ready  = (pairs != DEPTH);
    if (model_ok) begin
      check("m_count", 32'(count), 32'(pairs));
      check("m_in_ready", 32'(in_ready), 32'(ready));
      check("m_out_valid", 32'(out_valid), 32'(nbytes != 0));
      check("m_out_data", 32'(out_data), (nbytes != 0) ? 32'(exp_q[0]) : 32'd0);
      check("m_out_last", 32'(out_last), 32'((nbytes % 2) == 1));
      check("m_drop_count", 32'(drop_count), 32'(exp_drops));
    end
    if (rst) begin
      exp_q.delete();
      exp_drops = 0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (nbytes != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid) begin
        if (ready) begin
          exp_q.push_back(s1);
          exp_q.push_back(s2);
        end else if (exp_drops < 255) begin
          exp_drops++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    s1 = a;
    s2 = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2 * DEPTH + 2) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] fd_exp [8];
    fd_exp = '{8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83, 8'h04, 8'h84};

    // reset values
    tick();
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);

    // single pair
    out_ready = 1'b1;
    offer(8'h11, 8'h22);
    check("sp_data1", 32'(out_data), 32'h11);
    check("sp_last1", 32'(out_last), 32'd0);
    tick();
    check("sp_data2", 32'(out_data), 32'h22);
    check("sp_last2", 32'(out_last), 32'd1);
    tick();
    check("sp_valid_end", 32'(out_valid), 32'd0);
    check("sp_count_end", 32'(count), 32'd0);

    // fill and drop
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      offer(8'(i), 8'(8'h80 + i));
      if (i == 4) begin
        check("fd_count4", 32'(count), 32'd4);
        check("fd_in_ready4", 32'(in_ready), 32'd0);
      end
    end
    check("fd_drops", 32'(drop_count), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("fd_drain", 32'(out_data), 32'(fd_exp[i]));
      tick();
    end
    check("fd_empty", 32'(out_valid), 32'd0);

    // drop counter saturation
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s1 = 8'($urandom);
      s2 = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    check("sat_drop", 32'(drop_count), 32'd255);
    do_reset();
    check("sat_drop_rst", 32'(drop_count), 32'd0);

    // backpressure with random pairs
    begin
      int offered = 0;
      while (offered < 32) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        s1 = 8'($urandom);
        s2 = 8'($urandom);
        if (in_valid) offered++;
        tick();
      end
      in_valid = 1'b0;
    end
    drain();

    // wrap-around, one pair every other cycle
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(8'($urandom), 8'($urandom));
      check("wr_count_le1", 32'(count <= 1), 32'd1);
      tick();
      check("wr_count_le1b", 32'(count <= 1), 32'd1);
    end
    drain();

    // full with pop in same cycle
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(8'(8'h40 + i), 8'(8'hC0 + i));
    out_ready = 1'b1;
    tick();
    check("fp_s2_next", 32'(out_data), 32'hC0);
    offer(8'h5A, 8'hA5);
    check("fp_count3", 32'(count), 32'd3);
    check("fp_drop1", 32'(drop_count), 32'd1);
    drain();

    // reset mid-pair
    do_reset();
    out_ready = 1'b0;
    offer(8'hAA, 8'hBB);
    out_ready = 1'b1;
    tick();
    check("rm_half", 32'(out_data), 32'hBB);
    rst = 1'b1;
    in_valid = 1'b1;
    s1 = 8'h77;
    s2 = 8'h88;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rm_valid0", 32'(out_valid), 32'd0);
    check("rm_count0", 32'(count), 32'd0);
    check("rm_drop0", 32'(drop_count), 32'd0);
    offer(8'h33, 8'h44);
    check("rm_new_s1", 32'(out_data), 32'h33);
    tick();
    check("rm_new_s2", 32'(out_data), 32'h44);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
